freq_div_prog: RTL

Programmable clock-enable/clock divider. It is the parametrised successor to the fixed divide-by-10 divider: the divisor is runtime-loadable, the counter width is a parameter, and the block has an enable, a wrap tick and a pending-update status flag. It sits between the system clock and slow peripherals (display scan, debounce, CPU single-step). It produces a square-ish divided output `clk_out` and a one-cycle `tick` per output period.

---
 rtl/freq_div_prog.sv | 128 ++++++++++++
 1 files changed

// File: rtl/freq_div_prog.sv
// freq_div_prog -- programmable clock-enable / clock divider.
//
// Divides clk by a runtime-loadable divisor N (N >= 2). Each output period
// is N enabled clock cycles long. clk_out is low for ceil(N/2) cycles and
// high for floor(N/2) cycles. tick pulses for one cycle at the start of each
// period, which is the cycle in which count first reads 0.
//
// Build option: define FREQ_DIV_PROG_SYNC_UPDATE_EN for glitch-free divisor
// updates. A loaded divisor then waits in a pending register and becomes
// active at the next period wrap. When the macro is undefined, a load takes
// effect immediately and restarts the period.
//
// Parameters:
//   WIDTH        counter and divisor width
//   DEFAULT_DIV  active divisor after reset (2 .. 2^WIDTH-1)
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        count enable; when low, all counting state holds
//   div_in    new divisor value (values below 2 are stored as 2)
//   div_load  single-cycle load request for div_in
//   div_busy  a loaded divisor is pending (always 0 in immediate mode)
//   clk_out   divided clock, registered
//   tick      one-cycle pulse per period, registered
//   count     current counter value, for debug
module freq_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_act;
  logic             wrap;
  logic [WIDTH-1:0] cnt_inc;

  // Any divisor below 2 would make the counter degenerate.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(2)) ? WIDTH'(2) : v;
  endfunction

  // High phase starts at ceil(n/2); computed without a carry bit so that
  // n = 2^WIDTH-1 does not overflow.
  function automatic logic duty_high(input logic [WIDTH-1:0] c,
                                     input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] half;
    half = (n >> 1) + WIDTH'(n[0]);
    return c >= half;
  endfunction

  assign wrap    = (cnt == div_act - WIDTH'(1));
  assign cnt_inc = wrap ? '0 : cnt + WIDTH'(1);
  assign count   = cnt;

`ifdef FREQ_DIV_PROG_SYNC_UPDATE_EN
  logic [WIDTH-1:0] div_pend;
  logic             pend;
  logic             apply;
  logic [WIDTH-1:0] div_nxt;

  // The pending divisor is adopted only on an enabled wrap, so the new
  // period always starts from cnt = 0 and no runt pulse appears.
  assign apply    = en && wrap && pend;
  assign div_nxt  = apply ? div_pend : div_act;
  assign div_busy = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_act  <= WIDTH'(DEFAULT_DIV);
      div_pend <= '0;
      pend     <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (en) begin
        cnt     <= cnt_inc;
        div_act <= div_nxt;
        clk_out <= duty_high(cnt_inc, div_nxt);
        tick    <= wrap;
      end else begin
        tick    <= 1'b0;
      end
      // A load on the wrap edge itself is captured here and waits for the
      // following wrap; the previously pending value is applied above.
      if (div_load) begin
        div_pend <= clamp_div(div_in);
        pend     <= 1'b1;
      end else if (apply) begin
        pend     <= 1'b0;
      end
    end
  end
`else
  assign div_busy = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= WIDTH'(DEFAULT_DIV);
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (div_load) begin
      // Immediate restart with the new divisor, independent of en.
      div_act <= clamp_div(div_in);
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      cnt     <= cnt_inc;
      clk_out <= duty_high(cnt_inc, div_act);
      tick    <= wrap;
    end else begin
      tick    <= 1'b0;
    end
  end
`endif

endmodule
